multicycle_alu: RTL and testbench

- Execution stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code and two operands, and returns a registered result plus a zero flag.
- ADD/SUB/OR complete in one cycle; shifts iterate one bit per cycle.
- A start/busy/done handshake lets the sequencer stall while a shift runs.

---
 rtl/multicycle_alu.sv | 115 +++++++++++
 tb/tb_multicycle_alu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execution-stage ALU: one-cycle ADD/SUB/OR, bit-serial SLL/SRL with start/busy/done
// Optional macro BARREL_SHIFT_EN: shifts use a single-cycle barrel shifter.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;

`ifdef BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_WIDTH-1:0]  shamt;

  assign shamt = B_i[SHAMT_WIDTH-1:0];

`ifndef BARREL_SHIFT_EN
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    left_q, left_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
`ifndef BARREL_SHIFT_EN
      cnt_q    <= '0;
      left_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifndef BARREL_SHIFT_EN
      cnt_q    <= cnt_d;
      left_q   <= left_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef BARREL_SHIFT_EN
    cnt_d    = cnt_q;
    left_d   = left_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = DONE;
          case (ALU_Operation_i)
            OP_ADD: result_d = A_i + B_i;
            OP_SUB: result_d = A_i - B_i;
            OP_OR:  result_d = A_i | B_i;
`ifdef BARREL_SHIFT_EN
            OP_SLL: result_d = A_i << shamt;
            OP_SRL: result_d = A_i >> shamt;
`else
            // The result register doubles as the shift register.
            OP_SLL, OP_SRL: begin
              result_d = A_i;
              left_d   = (ALU_Operation_i == OP_SLL);
              cnt_d    = shamt;
              if (shamt != '0) state_d = SHIFT;
            end
`endif
            default: result_d = '0;
          endcase
        end
      end
`ifndef BARREL_SHIFT_EN
      SHIFT: begin
        result_d = left_q ? (result_q << 1) : (result_q >> 1);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHAMT_WIDTH'(1)) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign ALU_Result_o = result_q;
  assign Zero_o       = (result_q == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - randomized self-checking bench for multicycle_alu against a latency/result model
module tb_multicycle_alu;

`ifdef BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ALU_Operation_i = 4'd0;
  logic [31:0] A_i = 32'd0;
  logic [31:0] B_i = 32'd0;
  logic        busy_o, done_o, Zero_o;
  logic [31:0] ALU_Result_o;

  int total = 0;
  int bad = 0;

  multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
    .A_i(A_i), .B_i(B_i), .busy_o(busy_o), .done_o(done_o),
    .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a | b;
      4'd3: return a << b[4:0];
      4'd4: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    if (!BARREL && (op == 4'd3 || op == 4'd4)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Model: cycles left until the operation is finished (1 = done cycle) and the final result.
  int          remain = 0;
  logic [31:0] exp_res = 32'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain  <= 0;
      exp_res <= 32'd0;
    end else if (remain > 0) begin
      remain <= remain - 1;
    end else if (start_i) begin
      remain  <= latency(ALU_Operation_i, B_i);
      exp_res <= calc(ALU_Operation_i, A_i, B_i);
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy_o), 32'(remain > 0));
      check("done", 32'(done_o), 32'(remain == 1));
      // Intermediate shift values are not architecturally meaningful.
      if (remain <= 1) begin
        check("result", ALU_Result_o, exp_res);
        check("zero", 32'(Zero_o), 32'(exp_res == 32'd0));
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input bit hold);
    int k;
    logic [31:0] r;
    logic z;
    k = 0;
    r = 32'd0;
    z = 1'b0;
    @(negedge clk);
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    start_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        k = i;
        r = ALU_Result_o;
        z = Zero_o;
        break;
      end
      if (hold) begin
        ALU_Operation_i = 4'($urandom_range(0, 4));
        A_i = $urandom;
        B_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
    end
    if (k == 0) begin
      total++;
      bad++;
      $display("FAIL timeout: no done_o within 40 cycles op=%h", op);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      check("done_result", r, exp_r);
      check("done_zero", 32'(z), 32'(exp_r == 32'd0));
    end
    if (hold) @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    int n_done;
    logic [3:0] op;
    logic [31:0] a, b;

    // Reset with garbage on the inputs.
    cmp_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start_i = 1'b1;
      ALU_Operation_i = 4'($urandom);
      A_i = $urandom;
      B_i = $urandom;
    end
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", ALU_Result_o, 32'd0);
    check("rst_zero", 32'(Zero_o), 32'd1);
    start_i = 1'b0;
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'd0);

    run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1, 1'b0);
    run_op(4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
    run_op(4'b0010, 32'h0F00, 32'h00F0, 32'h0000_0FF0, 1, 1'b0);
    run_op(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, 1'b0);
    run_op(4'b0011, 32'h1, 32'd4, 32'h10, BARREL ? 1 : 5, 1'b0);
    run_op(4'b0100, 32'h8000_0000, 32'd31, 32'h1, BARREL ? 1 : 32, 1'b0);
    run_op(4'b0011, 32'h1234, 32'h25, 32'h0002_4680, BARREL ? 1 : 6, 1'b0);
    run_op(4'b0100, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, 1'b0);
    // start_i held through SHIFT and DONE with operands churning.
    run_op(4'b0011, 32'h3, 32'd6, 32'hC0, BARREL ? 1 : 7, 1'b1);
    run_op(4'b0001, 32'd100, 32'd58, 32'd42, 1, 1'b1);

    // Reset in the middle of a long shift.
    @(negedge clk);
    ALU_Operation_i = 4'b0011;
    A_i = 32'h1;
    B_i = 32'd20;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_done = 0;
    repeat (5) begin
      if (done_o) n_done++;
      @(negedge clk);
    end
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_result", ALU_Result_o, 32'd0);
    check("midrst_zero", 32'(Zero_o), 32'd1);
`ifndef BARREL_SHIFT_EN
    check("midrst_no_done", 32'(n_done), 32'd0);
`endif
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    run_op(4'b0000, 32'd2, 32'd3, 32'd5, 1, 1'b0);

    // Random operations; the per-cycle compare process does the checking.
    for (int t = 0; t < 80; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      run_op(op, a, b, calc(op, a, b), latency(op, b), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
